mult_booth: RTL and testbench

Sequential signed 32×32 multiplier using radix-2 Booth recoding. It produces a 64-bit product split into `hi` and `lo` in the HI/LO register convention the datapath already uses for the divider. It sits beside the divider in the Multiplier unit and is driven by the same control FSM for MULT. A start/done handshake replaces the divider's free-running evaluation.

---
 rtl/mult_pkg.sv | 16 +
 rtl/mult_booth_if.sv | 22 ++
 rtl/booth_step.sv | 31 +++
 rtl/mult_booth.sv | 97 +++++++++
 tb/tb_mult_booth.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential Booth multiplier.
package mult_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = $clog2(WIDTH_DEF + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Booth codes on {Q[0], q_1}
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/mult_booth_if.sv
// Start/done handshake and HI/LO result bus of the Booth multiplier.
interface mult_booth_if #(
  parameter int WIDTH = mult_pkg::WIDTH_DEF
);
  logic             start;
  logic [WIDTH-1:0] multiplicando;
  logic [WIDTH-1:0] multiplicador;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  modport master (
    output start, multiplicando, multiplicador,
    input  hi, lo, busy, done
  );

  modport slave (
    input  start, multiplicando, multiplicador,
    output hi, lo, busy, done
  );
endinterface

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: add/subtract/hold on {Q[0], q_1}, then an
// arithmetic right shift of the combined {A, Q, q_1} register.
module booth_step
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic signed [WIDTH:0]   a,
  input  logic signed [WIDTH:0]   m,
  input  logic        [WIDTH-1:0] q,
  input  logic                    q_1,
  output logic signed [WIDTH:0]   a_nx,
  output logic        [WIDTH-1:0] q_nx,
  output logic                    q_1_nx
);

  logic signed [WIDTH:0] sum;

  always_comb begin
    case ({q[0], q_1})
      BOOTH_ADD: sum = a + m;
      BOOTH_SUB: sum = a - m;
      default:   sum = a;
    endcase
    // A's LSB falls into Q's MSB; Q's LSB becomes the new guard bit
    a_nx   = sum >>> 1;
    q_nx   = {sum[0], q[WIDTH-1:1]};
    q_1_nx = q[0];
  end

endmodule

// File: rtl/mult_booth.sv
// Sequential signed WIDTH x WIDTH multiplier, one Booth iteration per cycle,
// result delivered on HI/LO with a single-cycle done pulse.
module mult_booth
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic         clock,
  input  logic         reset,
  mult_booth_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t                  state, state_nx;
  logic signed [WIDTH:0]   acc;
  logic signed [WIDTH:0]   mcand;
  logic        [WIDTH-1:0] mplier;
  logic                    guard;
  logic        [CNT_W-1:0] cnt;

  logic signed [WIDTH:0]   acc_nx;
  logic        [WIDTH-1:0] mplier_nx;
  logic                    guard_nx;

  logic load, step, last;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .a      (acc),
    .m      (mcand),
    .q      (mplier),
    .q_1    (guard),
    .a_nx   (acc_nx),
    .q_nx   (mplier_nx),
    .q_1_nx (guard_nx)
  );

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    step     = 1'b0;
    last     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load     = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == CNT_W'(1)) begin
          last     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      guard    <= 1'b0;
      cnt      <= '0;
      bus.hi   <= '0;
      bus.lo   <= '0;
      bus.done <= 1'b0;
    end else begin
      state    <= state_nx;
      bus.done <= last;
      if (load) begin
        acc    <= '0;
        mcand  <= {bus.multiplicando[WIDTH-1], bus.multiplicando};
        mplier <= bus.multiplicador;
        guard  <= 1'b0;
        cnt    <= CNT_W'(WIDTH);
      end else if (step) begin
        acc    <= acc_nx;
        mplier <= mplier_nx;
        guard  <= guard_nx;
        cnt    <= cnt - CNT_W'(1);
      end
      // HI/LO change only as a complete pair on the final iteration
      if (last) begin
        bus.hi <= acc_nx[WIDTH-1:0];
        bus.lo <= mplier_nx;
      end
    end
  end

  assign bus.busy = (state == RUN);

endmodule

// File: tb/tb_mult_booth.sv
// Scoreboard bench for mult_booth: directed corner cases plus random signed
// operand pairs against a 64-bit arithmetic reference.
module tb_mult_booth;
  import mult_pkg::*;

  localparam int W = 32;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_fail;

  typedef struct {
    int          due;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  exp_t sb[$];

  logic [W-1:0] last_hi, last_lo;
  logic         prev_done;

  mult_booth_if #(.WIDTH(W)) bus ();

  mult_booth #(.WIDTH(W)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse, checks handshake rules
  always @(negedge clk) begin
    if (!rst_n) begin
      last_hi   = '0;
      last_lo   = '0;
      prev_done = 1'b0;
    end else begin
      check("busy_done_overlap", 64'(bus.busy & bus.done), 64'd0);
      if (bus.done) begin
        check("done_width", 64'(prev_done), 64'd0);
        if (sb.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("latency", 64'(cyc), 64'(e.due));
          check("hi", 64'(bus.hi), 64'(e.hi));
          check("lo", 64'(bus.lo), 64'(e.lo));
        end
        last_hi = bus.hi;
        last_lo = bus.lo;
      end else begin
        check("hi_stable", 64'(bus.hi), 64'(last_hi));
        check("lo_stable", 64'(bus.lo), 64'(last_lo));
      end
      prev_done = bus.done;
    end
  end

  function automatic logic [63:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb_;
    sa  = longint'($signed(a));
    sb_ = longint'($signed(b));
    return 64'(sa * sb_);
  endfunction

  // Waits for busy low, presents a one-cycle start, and logs the expectation
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eh, input logic [W-1:0] el);
    int guard_cnt;
    exp_t e;
    guard_cnt = 0;
    @(negedge clk);
    while (bus.busy && guard_cnt < 200) begin
      @(negedge clk);
      guard_cnt++;
    end
    if (bus.busy) check("issue_timeout", 64'd1, 64'd0);
    bus.start         = 1'b1;
    bus.multiplicando = a;
    bus.multiplicador = b;
    @(posedge clk);
    #1;
    e.due = cyc + W;
    e.hi  = eh;
    e.lo  = el;
    sb.push_back(e);
    bus.start         = 1'b0;
    bus.multiplicando = $urandom;
    bus.multiplicador = $urandom;
    check("busy_after_start", 64'(bus.busy), 64'd1);
  endtask

  task automatic issue_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] p;
    p = ref_prod(a, b);
    issue(a, b, p[63:32], p[31:0]);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) check("wait_done_timeout", 64'd1, 64'd0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks          = 0;
    n_fail            = 0;
    rst_n             = 1'b0;
    bus.start         = 1'b0;
    bus.multiplicando = '0;
    bus.multiplicador = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hi", 64'(bus.hi), 64'd0);
    check("rst_lo", 64'(bus.lo), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    rst_n = 1'b1;

    issue(32'd3, 32'd5, 32'h0000_0000, 32'h0000_000F);
    issue(32'hFFFF_FFF9, 32'h0000_0006, 32'hFFFF_FFFF, 32'hFFFF_FFD6);
    issue(32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    drain();

    // A start pulse while busy must be dropped
    issue(32'd2, 32'd2, 32'd0, 32'd4);
    repeat (9) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.multiplicando = 32'd9; bus.multiplicador = 32'd9;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done();
    // Back-to-back: start accepted in the done cycle
    bus.start = 1'b1; bus.multiplicando = 32'hFFFF_FFFF; bus.multiplicador = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    begin
      exp_t e;
      e.due = cyc + W; e.hi = 32'd0; e.lo = 32'd1;
      sb.push_back(e);
    end
    bus.start = 1'b0;
    check("b2b_busy", 64'(bus.busy), 64'd1);
    drain();
    repeat (5) @(posedge clk);

    // Asynchronous abort mid-run
    issue_ref(32'h1234_5678, 32'h9ABC_DEF0);
    repeat (14) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("abort_hi", 64'(bus.hi), 64'd0);
    check("abort_lo", 64'(bus.lo), 64'd0);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    issue_ref(32'h1234_5678, 32'h9ABC_DEF0);
    drain();

    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] a, b;
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: a = 32'h8000_0000;
        1: b = 32'h7FFF_FFFF;
        2: a = 32'hFFFF_FFFF;
        3: b = 32'd0;
        default: ;
      endcase
      issue_ref(a, b);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) @(posedge clk);
    end
    drain();
    repeat (40) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
